// File: rtl/fetch_byte_sequencer_if.sv
// Memory byte-request and issue-FIFO ports of the fetch byte sequencer.
// master = sequencer side, slave = memory / micro-instruction queue side.
interface fetch_byte_sequencer_if #(
  parameter int MQ_N   = 4,
  parameter int ADDR_W = 32,
  parameter int MI_W   = 32
);
  logic                        mem_req;
  logic [ADDR_W-1:0]           mem_addr;
  logic                        mem_ack;
  logic [7:0]                  mem_byte;
  logic                        iss_valid;
  logic                        iss_ready;
  logic [MQ_N-1:0][MI_W-1:0]   iss_miinst;
  logic [ADDR_W-1:0]           iss_pc;
  logic [3:0]                  iss_len;

  modport master (
    output mem_req, mem_addr, iss_valid, iss_miinst, iss_pc, iss_len,
    input  mem_ack, mem_byte, iss_ready
  );
  modport slave (
    input  mem_req, mem_addr, iss_valid, iss_miinst, iss_pc, iss_len,
    output mem_ack, mem_byte, iss_ready
  );
endinterface

// File: rtl/fetch_byte_sequencer.sv
// Byte-serial fetch sequencer: one outstanding byte request, decode-chain operand registers,
// 2-entry issue FIFO, redirect/flush. FETCH_INST_LEN_CHECK_EN enables the 16-byte length fault.
module fetch_byte_sequencer #(
  parameter int          MQ_N     = 4,
  parameter int          ADDR_W   = 32,
  parameter int unsigned PC_RESET = 0,
  parameter int          MI_W     = 32,
  parameter int          NAME_W   = 8,
  parameter int          CI_W     = 36
) (
  input  logic                      clk,
  input  logic                      rstn,
  fetch_byte_sequencer_if.master    bus,
  output logic [7:0]                cur_byte,
  output logic [ADDR_W-1:0]         cur_pc,
  output logic [11:0]               cur_state,
  output logic [MQ_N-1:0][MI_W-1:0] cur_miinst,
  output logic [NAME_W-1:0]         cur_name,
  output logic [CI_W-1:0]           cur_imm,
  output logic [CI_W-1:0]           cur_disp,
  output logic [3:0]                cur_rex,
  input  logic [11:0]               nxt_state,
  input  logic [MQ_N-1:0][MI_W-1:0] nxt_miinst,
  input  logic [NAME_W-1:0]         nxt_name,
  input  logic [CI_W-1:0]           nxt_imm,
  input  logic [CI_W-1:0]           nxt_disp,
  input  logic [3:0]                nxt_rex,
  input  logic                      phase_valid,
  input  logic                      redir_valid,
  input  logic [ADDR_W-1:0]         redir_pc,
  output logic                      len_fault
);
  // fstate layout {obj, grp, dst}; a fresh instruction starts at obj=OPCODE_1
  localparam int               ST_W         = 12;
  localparam logic [3:0]       OBJ_OPCODE_1 = 4'd1;
  localparam logic [ST_W-1:0]  ST_INIT      = {OBJ_OPCODE_1, 8'h00};
  localparam logic [ADDR_W-1:0] PC_INIT     = ADDR_W'(PC_RESET);

  typedef enum logic [1:0] {RUN, STALL, DROP} fsm_e;

  typedef struct packed {
    logic [ST_W-1:0]           st;
    logic [MQ_N-1:0][MI_W-1:0] mi;
    logic [NAME_W-1:0]         name;
    logic [CI_W-1:0]           imm;
    logic [CI_W-1:0]           disp;
    logic [3:0]                rex;
  } dec_t;

  typedef struct packed {
    logic [MQ_N-1:0][MI_W-1:0] mi;
    logic [ADDR_W-1:0]         pc;
    logic [3:0]                len;
  } iss_t;

  localparam dec_t DEC_INIT = {ST_INIT, {($bits(dec_t)-ST_W){1'b0}}};

  fsm_e              fsm_q, fsm_d;
  logic              live_q;
  logic [ADDR_W-1:0] pc_q, pc_d, drop_addr_q, drop_addr_d;
  logic [ADDR_W-1:0] cur_pc_q, cur_pc_d, start_pc_q, start_pc_d;
  logic [7:0]        byte_q, byte_d;
  logic              pend_q, pend_d;
  logic [3:0]        len_q, len_d;
  dec_t              dec_q, dec_d, dec_nxt;
  iss_t [1:0]        fifo_q, fifo_d;
  iss_t              new_ent;
  logic [1:0]        cnt_q, cnt_d;
  logic              mem_req, consume, eval, push, pop, kill;

  assign mem_req = live_q && (fsm_q != STALL);
  assign consume = mem_req && bus.mem_ack && (fsm_q == RUN) && !redir_valid;
  assign eval    = pend_q && !redir_valid;
  assign push    = eval && phase_valid;
  assign pop     = bus.iss_valid && bus.iss_ready && !redir_valid;

`ifdef FETCH_INST_LEN_CHECK_EN
  // a 16th byte without completion can never be a legal x86 instruction
  assign kill      = eval && !phase_valid && (len_q == 4'd15);
  assign len_fault = kill;
`else
  assign kill      = 1'b0;
  assign len_fault = 1'b0;
`endif

  always_comb begin
    dec_nxt = '{st: nxt_state, mi: nxt_miinst, name: nxt_name,
                imm: nxt_imm, disp: nxt_disp, rex: nxt_rex};
    new_ent.mi  = nxt_miinst;
    new_ent.pc  = (len_q == 4'd0) ? cur_pc_q : start_pc_q;
    new_ent.len = (len_q == 4'd15) ? 4'd15 : len_q + 4'd1;
  end

  always_comb begin
    fsm_d       = fsm_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    cur_pc_d    = cur_pc_q;
    start_pc_d  = start_pc_q;
    byte_d      = byte_q;
    pend_d      = pend_q;
    len_d       = len_q;
    dec_d       = dec_q;
    fifo_d      = fifo_q;
    cnt_d       = cnt_q;

    if (consume) begin
      byte_d   = bus.mem_byte;
      cur_pc_d = pc_q;
      pc_d     = pc_q + 1'b1;
      pend_d   = 1'b1;
    end

    if (eval) begin
      pend_d = 1'b0;
      if (len_q == 4'd0) start_pc_d = cur_pc_q;
      if (push || kill) begin
        dec_d = DEC_INIT;
        len_d = 4'd0;
      end else begin
        dec_d = dec_nxt;
        if (len_q != 4'd15) len_d = len_q + 4'd1;
      end
    end

    // head always in slot 0; the post-pop count picks the free slot
    if (pop) begin
      fifo_d[0] = fifo_q[1];
      cnt_d     = cnt_q - 2'd1;
    end
    if (push) begin
      fifo_d[cnt_d[0]] = new_ent;
      cnt_d            = cnt_d + 2'd1;
    end

    if (redir_valid) begin
      cnt_d  = 2'd0;
      pend_d = 1'b0;
      dec_d  = DEC_INIT;
      len_d  = 4'd0;
      pc_d   = redir_pc;
    end

    if (fsm_q == DROP) begin
      if (bus.mem_ack) fsm_d = RUN;
    end else if (redir_valid && mem_req && !bus.mem_ack) begin
      fsm_d       = DROP;
      drop_addr_d = pc_q;
    end else begin
      fsm_d = (cnt_d == 2'd2 || pend_d) ? STALL : RUN;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fsm_q       <= RUN;
      live_q      <= 1'b0;
      pc_q        <= PC_INIT;
      drop_addr_q <= PC_INIT;
      cur_pc_q    <= PC_INIT;
      start_pc_q  <= PC_INIT;
      byte_q      <= 8'h00;
      pend_q      <= 1'b0;
      len_q       <= 4'd0;
      dec_q       <= DEC_INIT;
      fifo_q      <= '0;
      cnt_q       <= 2'd0;
    end else begin
      fsm_q       <= fsm_d;
      live_q      <= 1'b1;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      cur_pc_q    <= cur_pc_d;
      start_pc_q  <= start_pc_d;
      byte_q      <= byte_d;
      pend_q      <= pend_d;
      len_q       <= len_d;
      dec_q       <= dec_d;
      fifo_q      <= fifo_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.mem_req    = mem_req;
  assign bus.mem_addr   = (fsm_q == DROP) ? drop_addr_q : pc_q;
  assign bus.iss_valid  = (cnt_q != 2'd0);
  assign bus.iss_miinst = fifo_q[0].mi;
  assign bus.iss_pc     = fifo_q[0].pc;
  assign bus.iss_len    = fifo_q[0].len;

  assign cur_byte   = byte_q;
  assign cur_pc     = cur_pc_q;
  assign cur_state  = dec_q.st;
  assign cur_miinst = dec_q.mi;
  assign cur_name   = dec_q.name;
  assign cur_imm    = dec_q.imm;
  assign cur_disp   = dec_q.disp;
  assign cur_rex    = dec_q.rex;
endmodule

// File: tb/tb_fetch_byte_sequencer.sv
// Directed bench for fetch_byte_sequencer: bench acts as memory and decode chain,
// issued instructions are checked against a scoreboard queue.
module tb_fetch_byte_sequencer;
  localparam int MQ_N = 4;
  localparam int AW   = 32;

  typedef struct {
    logic [AW-1:0]  pc;
    logic [3:0]     len;
    logic [127:0]   mi;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  logic [7:0] cur_byte;
  logic [AW-1:0] cur_pc;
  logic [11:0] cur_state, nxt_state;
  logic [MQ_N-1:0][31:0] cur_miinst, nxt_miinst;
  logic [7:0] cur_name, nxt_name;
  logic [35:0] cur_imm, cur_disp, nxt_imm, nxt_disp;
  logic [3:0] cur_rex, nxt_rex;
  logic phase_valid, redir_valid, len_fault;
  logic [AW-1:0] redir_pc;

  logic auto_ack, fixed_byte, man_ack;
  logic [7:0] man_byte;
  logic [1:0] pv_mode;
  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  fetch_byte_sequencer_if #(.MQ_N(MQ_N), .ADDR_W(AW), .MI_W(32)) bus ();

  fetch_byte_sequencer #(.MQ_N(MQ_N), .ADDR_W(AW), .PC_RESET(0)) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .cur_byte(cur_byte), .cur_pc(cur_pc), .cur_state(cur_state),
    .cur_miinst(cur_miinst), .cur_name(cur_name), .cur_imm(cur_imm),
    .cur_disp(cur_disp), .cur_rex(cur_rex),
    .nxt_state(nxt_state), .nxt_miinst(nxt_miinst), .nxt_name(nxt_name),
    .nxt_imm(nxt_imm), .nxt_disp(nxt_disp), .nxt_rex(nxt_rex),
    .phase_valid(phase_valid), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .len_fault(len_fault)
  );

  always #5 clk = ~clk;

  // memory: zero-wait auto mode, or manual ack/byte
  assign bus.mem_ack  = auto_ack ? bus.mem_req : man_ack;
  assign bus.mem_byte = auto_ack ? (fixed_byte ? 8'h90 : bus.mem_addr[7:0] + 8'h10) : man_byte;

  // decode chain model: state counts bytes, slot 0 shifts in bytes
  assign nxt_state   = cur_state + 12'd1;
  assign nxt_miinst  = {cur_miinst[MQ_N-1:1], cur_miinst[0][23:0], cur_byte};
  assign nxt_name    = cur_name ^ cur_byte;
  assign nxt_imm     = cur_imm + 36'd1;
  assign nxt_disp    = cur_disp;
  assign nxt_rex     = cur_byte[3:0];
  assign phase_valid = (pv_mode == 2'd1) || (pv_mode == 2'd2 && cur_state[3:0] == 4'd4);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [AW-1:0] pc, input logic [3:0] len, input logic [127:0] mi);
    exp_t e;
    e.pc = pc; e.len = len; e.mi = mi;
    exp_q.push_back(e);
  endtask

  // reset mid-whatever, then release; returns in cycle 0 after release
  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("rst_req_abandon", bus.mem_req, 1'b0);
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rstn === 1'b1 && bus.iss_valid && bus.iss_ready && !redir_valid) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexp_issue observed pc=%0h len=%0d expected none", bus.iss_pc, bus.iss_len);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("iss_pc", bus.iss_pc, e.pc);
        chk("iss_len", bus.iss_len, e.len);
        chk("iss_miinst", bus.iss_miinst, e.mi);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, last_pulse, saw_iss;
    rstn = 1'b0; auto_ack = 1'b0; fixed_byte = 1'b1; man_ack = 1'b0; man_byte = 8'h00;
    pv_mode = 2'd1; redir_valid = 1'b0; redir_pc = '0;
    bus.iss_ready = 1'b1;

    // 1: reset values, then three 1-byte 0x90 instructions
    repeat (2) tick();
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_cur_pc", cur_pc, 32'h0);
    chk("rst_iss_valid", bus.iss_valid, 1'b0);
    chk("rst_len_fault", len_fault, 1'b0);
    chk("rst_cur_state", cur_state, 12'h100);
    chk("rst_cur_miinst", cur_miinst, 128'h0);
    auto_ack = 1'b1;
    rstn = 1'b1;
    push_exp(32'd0, 4'd1, 128'h90);
    push_exp(32'd1, 4'd1, 128'h90);
    push_exp(32'd2, 4'd1, 128'h90);
    chk("t1_c0_req", bus.mem_req, 1'b0);
    tick();
    chk("t1_c1_req", bus.mem_req, 1'b1);
    chk("t1_c1_addr", bus.mem_addr, 32'd0);
    tick();
    chk("t1_c2_req", bus.mem_req, 1'b0);
    chk("t1_c2_iss", bus.iss_valid, 1'b0);
    tick();
    chk("t1_c3_iss", bus.iss_valid, 1'b1);
    chk("t1_c3_addr", bus.mem_addr, 32'd1);
    repeat (3) tick();
    auto_ack = 1'b0;
    tick();
    chk("t1_c7_req", bus.mem_req, 1'b1);
    chk("t1_c7_addr", bus.mem_addr, 32'd3);
    tick();
    chk("t1_q_empty", exp_q.size(), 0);

    // 2: FIFO full stalls fetch, release resumes at pc 2
    bus.iss_ready = 1'b0;
    do_reset();
    auto_ack = 1'b1; fixed_byte = 1'b1; pv_mode = 2'd1;
    push_exp(32'd0, 4'd1, 128'h90);
    push_exp(32'd1, 4'd1, 128'h90);
    repeat (5) tick();
    chk("t2_c5_req", bus.mem_req, 1'b0);
    tick();
    chk("t2_c6_req", bus.mem_req, 1'b0);
    tick();
    chk("t2_c7_req", bus.mem_req, 1'b0);
    chk("t2_c7_iss", bus.iss_valid, 1'b1);
    tick();
    bus.iss_ready = 1'b1; auto_ack = 1'b0;
    chk("t2_c8_req", bus.mem_req, 1'b0);
    tick();
    chk("t2_c9_req", bus.mem_req, 1'b1);
    chk("t2_c9_addr", bus.mem_addr, 32'd2);
    tick();
    chk("t2_c10_iss", bus.iss_valid, 1'b0);
    chk("t2_q_empty", exp_q.size(), 0);

    // 3: 5-byte instruction with state feedback
    do_reset();
    auto_ack = 1'b1; fixed_byte = 1'b0; pv_mode = 2'd2;
    push_exp(32'd0, 4'd5, 128'h11121314);
    for (int cyc = 1; cyc <= 11; cyc++) begin
      tick();
      if (cyc == 2) begin
        chk("t3_cur_byte", cur_byte, 8'h10);
        chk("t3_cur_pc", cur_pc, 32'd0);
      end
      if (cyc == 7) chk("t3_state_fb", cur_state, 12'h103);
      if (cyc == 10) begin
        auto_ack = 1'b0;
        chk("t3_c10_iss", bus.iss_valid, 1'b0);
      end
      if (cyc == 11) begin
        chk("t3_c11_iss", bus.iss_valid, 1'b1);
        chk("t3_state_init", cur_state, 12'h100);
        chk("t3_rex_init", cur_rex, 4'h0);
        chk("t3_mi_init", cur_miinst, 128'h0);
      end
    end
    tick();
    chk("t3_q_empty", exp_q.size(), 0);

    // 4: redirect while request unacked -> drop one ack, refetch at 0x100
    do_reset();
    auto_ack = 1'b0; pv_mode = 2'd1;
    redir_valid = 1'b1; redir_pc = 32'h7;
    tick();
    redir_valid = 1'b0;
    chk("t4_c1_req", bus.mem_req, 1'b1);
    chk("t4_c1_addr", bus.mem_addr, 32'h7);
    tick();
    redir_valid = 1'b1; redir_pc = 32'h100;
    tick();
    redir_valid = 1'b0;
    chk("t4_drop_req", bus.mem_req, 1'b1);
    chk("t4_drop_addr", bus.mem_addr, 32'h7);
    tick();
    chk("t4_drop_addr2", bus.mem_addr, 32'h7);
    man_ack = 1'b1; man_byte = 8'hAA;
    tick();
    chk("t4_new_req", bus.mem_req, 1'b1);
    chk("t4_new_addr", bus.mem_addr, 32'h100);
    chk("t4_iss_empty", bus.iss_valid, 1'b0);
    chk("t4_byte_dropped", cur_byte, 8'h00);
    push_exp(32'h100, 4'd1, 128'h42);
    man_byte = 8'h42;
    tick();
    man_ack = 1'b0;
    chk("t4_cur_byte", cur_byte, 8'h42);
    chk("t4_cur_pc", cur_pc, 32'h100);
    tick();
    chk("t4_iss", bus.iss_valid, 1'b1);
    tick();
    chk("t4_q_empty", exp_q.size(), 0);

    // 5: redirect beats same-cycle push and pop
    bus.iss_ready = 1'b0;
    do_reset();
    auto_ack = 1'b1; fixed_byte = 1'b1; pv_mode = 2'd1;
    repeat (4) tick();
    bus.iss_ready = 1'b1; auto_ack = 1'b0;
    redir_valid = 1'b1; redir_pc = 32'h40;
    chk("t5_c4_iss", bus.iss_valid, 1'b1);
    tick();
    redir_valid = 1'b0;
    chk("t5_iss_flushed", bus.iss_valid, 1'b0);
    chk("t5_req", bus.mem_req, 1'b1);
    chk("t5_addr", bus.mem_addr, 32'h40);
    chk("t5_state", cur_state, 12'h100);
    tick();
    chk("t5_iss_flushed2", bus.iss_valid, 1'b0);
    chk("t5_q_empty", exp_q.size(), 0);

    // 6: 16 bytes without completion
    do_reset();
    auto_ack = 1'b1; fixed_byte = 1'b1; pv_mode = 2'd0;
    pulses = 0; last_pulse = 0; saw_iss = 0;
    for (int cyc = 1; cyc <= 34; cyc++) begin
      tick();
      if (len_fault) begin pulses++; last_pulse = cyc; end
      if (bus.iss_valid) saw_iss++;
`ifdef FETCH_INST_LEN_CHECK_EN
      if (cyc == 33) chk("t6_state_init", cur_state, 12'h100);
`else
      if (cyc == 33) chk("t6_state_16", cur_state, 12'h110);
`endif
    end
`ifdef FETCH_INST_LEN_CHECK_EN
    chk("t6_pulses", pulses, 1);
    chk("t6_pulse_cycle", last_pulse, 32);
`else
    chk("t6_pulses", pulses, 0);
`endif
    chk("t6_no_issue", saw_iss, 0);
    auto_ack = 1'b0;
    rstn = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_byte_sequencer.md
# fetch_byte_sequencer

Sequencing controller for the byte-serial fetch/decode chain. Owns the pipeline registers that feed the combinational fetch-phase modules (state, micro-instruction slots, name, immediate/displacement info, REX bits) and drives the one-outstanding byte request to instruction memory. Packs each completed x86 instruction into a 2-entry issue FIFO toward the micro-instruction queue, and handles branch redirect and flush.

## Interface
- `MQ_N`, default 4: micro-instruction slots per x86 instruction.
- `ADDR_W`, default 32: byte-address width.
- `PC_RESET`, default 0: fetch address after reset.
- `clk` in 1: clock.
- `rstn` in 1: reset. One clock; reset is asynchronous and active-low.
- `mem_req` out 1: byte fetch request. Held until `mem_ack`.
- `mem_addr` out ADDR_W: byte address. Stable while `mem_req && !mem_ack`.
- `mem_ack` in 1, `mem_byte` in 8: returned byte, valid when `mem_ack`.
- `cur_byte` out 8, `cur_pc` out ADDR_W, `cur_state` out fstate, `cur_miinst` out miinst_t[MQ_N], `cur_name` out name_t, `cur_imm`/`cur_disp` out const_info_t, `cur_rex` out 4: registered operands for the phase chain.
- `nxt_state`, `nxt_miinst`, `nxt_name`, `nxt_imm`, `nxt_disp`, `nxt_rex` in (matching types): combinational chain results for `cur_byte`.
- `phase_valid` in 1: chain reports the instruction complete on this byte.
- `iss_valid` out 1, `iss_ready` in 1, `iss_miinst` out miinst_t[MQ_N], `iss_pc` out ADDR_W, `iss_len` out 4: issue port (FIFO head).
- `redir_valid` in 1, `redir_pc` in ADDR_W: flush and refetch.
- `len_fault` out 1: over-length pulse. See Configuration.

## Operation
- Byte consume: `mem_ack` while not dropping. `cur_byte` ← `mem_byte`. `pc` ← `pc+1`. On the following cycle the chain evaluates `cur_byte`. On that cycle the `cur_*` registers load `nxt_*`, and `len` increments. `start_pc` latches `cur_pc` when `len==0`.
- Completion: `phase_valid` on an evaluate cycle pushes {`nxt_miinst`, `start_pc`, `len+1`} into the FIFO. Decode registers then reset to their initial values: state.obj=OPCODE_1, dst/grp/miinst/name/imm/disp/rex zero, `len` 0.
- FSM states:
  - RUN: `mem_req`=1 when no byte is awaiting evaluation.
  - STALL: FIFO count 2 or a byte pending; `mem_req`=0. RUN↔STALL is evaluated every cycle.
  - DROP: entered on `redir_valid` while `mem_req && !mem_ack`. Old `mem_addr` is held. The next `mem_ack` is discarded, then the FSM returns to RUN.
- Redirect: FIFO emptied, decode registers initialised, any pending byte discarded, `pc` ← `redir_pc`. Redirect wins over a same-cycle push, pop or consume. A `mem_ack` in the redirect cycle itself is discarded, and DROP is not entered.
- FIFO: push and pop in the same cycle leave count unchanged. A push while full is impossible by construction (request gating).

## Timing
- Reset values:
  - `mem_req` 0 (first request the cycle after `rstn` rises), `mem_addr`/`cur_pc` PC_RESET.
  - All `cur_*` at their initial values, `iss_valid` 0, FIFO empty, `len_fault` 0, FSM RUN.
- Asserting `rstn` low mid-transaction abandons the request immediately. No ack is expected afterwards.
- Throughput: one byte per 2 cycles (request/ack, then evaluate). With a zero-wait memory (same-cycle `mem_ack`), an n-byte instruction appears on `iss_valid` 2n cycles after its first request.
- Issue latency: `iss_valid` rises the cycle after the completing evaluate cycle.
- Redirect: `mem_req` with `mem_addr=redir_pc` appears the cycle after `redir_valid` (RUN case), or the cycle after the dropped ack (DROP case).

## Configuration
- `FETCH_INST_LEN_CHECK_EN` defined:
  - If an evaluate cycle would make `len`=16 without `phase_valid`, `len_fault` pulses for 1 cycle.
  - Decode registers are initialised and nothing is pushed.
  - Fetch continues at the current `pc`.
- `FETCH_INST_LEN_CHECK_EN` undefined: no check. `len` saturates at 15 and `len_fault` is tied 0.

## Test plan
- Reset, zero-wait memory returning 0x90 (1-byte instruction with `phase_valid` on every byte) → three pushes with `iss_pc` 0,1,2 and `iss_len` 1. `mem_req` rises cycle 1.
- Hold `iss_ready`=0, feed 1-byte instructions → after 2 pushes `mem_req`=0 and STALL holds. Release `iss_ready` → request resumes the next cycle at `pc`=2.
- 5-byte instruction (`phase_valid` on byte 5) → single push with `iss_len`=5 and `iss_pc`=`start_pc`. `cur_state` is fed back between bytes.
- `redir_valid` with `redir_pc`=0x100 while a request at 0x7 is unacked → `mem_addr` stays 0x7 until ack, the byte is ignored, the next `mem_addr` is 0x100, and the FIFO is empty.
- Redirect in the same cycle as a completing push and `iss_ready`=1 → FIFO empty afterwards, no stale `iss_valid`.
- With `FETCH_INST_LEN_CHECK_EN`: 16 bytes without `phase_valid` → one `len_fault` pulse on the 16th evaluate cycle and no push. Without the macro, `len_fault` stays 0.
